// File: rtl/morse_decoder.sv
// -----------------------------------------------------------------------------
// morse_decoder
//
// Decodes a serial Morse line carrying one of the letters I..P. The line is
// synchronised, then sampled once per Morse unit (rate+1 clocks). Mark runs
// are classified into dots (1 unit) and dashes (3 units). Up to four elements
// are collected. A 3-unit space ends the letter, which is then decoded.
//
// Ports
//   clock        in   1   system clock, rising edge
//   aresetn      in   1   asynchronous active-low reset
//   morse_in     in   1   raw Morse line (1 = mark, 0 = space)
//   rate         in  32   unit-period reload value (unit = rate+1 clocks)
//   letter       out  3   last valid letter: 000=I .. 111=P
//   letter_valid out  1   one-clock pulse when letter updates
//   letter_err   out  1   one-clock pulse when a malformed/unknown letter ends
//   busy         out  1   high while the decoder is not idle
//   err_count    out  8   saturating count of letter_err pulses
//
// Configuration
//   MORSE_DECODER_ERRCNT_EN  defined  : err_count counts letter_err pulses,
//                                       saturating at 255
//                            undefined: err_count is tied to zero
// -----------------------------------------------------------------------------
module morse_decoder (
  input  logic        clock,
  input  logic        aresetn,
  input  logic        morse_in,
  input  logic [31:0] rate,
  output logic [2:0]  letter,
  output logic        letter_valid,
  output logic        letter_err,
  output logic        busy,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  // Decode result packed as {ok, letter_code}.
  function automatic logic [3:0] decode(input logic [2:0] cnt,
                                        input logic [3:0] bits,
                                        input logic       bad);
    logic [3:0] res;
    res = 4'b0000;
    if (!bad) begin
      case (cnt)
        3'd2: begin
          case (bits[1:0])
            2'b00:   res = {1'b1, 3'b000};  // I ..
            2'b11:   res = {1'b1, 3'b100};  // M --
            2'b10:   res = {1'b1, 3'b101};  // N -.
            default: res = 4'b0000;
          endcase
        end
        3'd3: begin
          case (bits[2:0])
            3'b101:  res = {1'b1, 3'b010};  // K -.-
            3'b111:  res = {1'b1, 3'b110};  // O ---
            default: res = 4'b0000;
          endcase
        end
        3'd4: begin
          case (bits)
            4'b0111: res = {1'b1, 3'b001};  // J .---
            4'b0100: res = {1'b1, 3'b011};  // L .-..
            4'b0110: res = {1'b1, 3'b111};  // P .--.
            default: res = 4'b0000;
          endcase
        end
        default: res = 4'b0000;
      endcase
    end
    return res;
  endfunction

  logic        r_sync_p0;
  logic        r_sync_p1;
  logic [31:0] r_cnt;
  logic        w_tick;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_run;
  logic [2:0]  w_run_nxt;
  logic [3:0]  r_bits;
  logic [3:0]  w_bits_nxt;
  logic [2:0]  r_count;
  logic [2:0]  w_count_nxt;
  logic        r_bad;
  logic        w_bad_nxt;

  logic [2:0]  r_letter;
  logic [2:0]  w_letter_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_err;
  logic        w_err_nxt;

  logic        w_elem;
  logic [3:0]  w_dec;

  // Stage p0/p1: two-flop synchroniser on the asynchronous Morse line.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= morse_in;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Unit timer: a new rate value is only picked up at the next reload.
  assign w_tick = (r_cnt == 32'd0);

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= rate;
    end else if (w_tick) begin
      r_cnt <= rate;
    end else begin
      r_cnt <= r_cnt - 32'd1;
    end
  end

  // A mark run of exactly 3 units is a dash; anything else appended as a dot
  // (run lengths other than 1 or 3 also raise the bad flag).
  assign w_elem = (r_run == 3'd3);
  assign w_dec  = decode(r_count, r_bits, r_bad);

  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = r_run;
    w_bits_nxt   = r_bits;
    w_count_nxt  = r_count;
    w_bad_nxt    = r_bad;
    w_letter_nxt = r_letter;
    w_valid_nxt  = 1'b0;
    w_err_nxt    = 1'b0;

    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (r_sync_p1) begin
            w_state_nxt = ST_MARK;
            w_run_nxt   = 3'd1;
          end
        end

        ST_MARK: begin
          if (r_sync_p1) begin
            if (r_run != 3'd7) begin
              w_run_nxt = r_run + 3'd1;
            end
          end else begin
            if ((r_run != 3'd1) && (r_run != 3'd3)) begin
              w_bad_nxt = 1'b1;
            end
            if (r_count < 3'd4) begin
              w_bits_nxt  = {r_bits[2:0], w_elem};
              w_count_nxt = r_count + 3'd1;
            end else begin
              // Fifth element: letter is too long, element dropped.
              w_bad_nxt = 1'b1;
            end
            w_state_nxt = ST_SPACE;
            w_run_nxt   = 3'd1;
          end
        end

        ST_SPACE: begin
          if (r_sync_p1) begin
            // A 2-unit gap is neither an element gap nor a letter gap.
            if (r_run == 3'd2) begin
              w_bad_nxt = 1'b1;
            end
            w_state_nxt = ST_MARK;
            w_run_nxt   = 3'd1;
          end else if (r_run == 3'd2) begin
            // Third space unit: letter boundary.
            if (w_dec[3]) begin
              w_letter_nxt = w_dec[2:0];
              w_valid_nxt  = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
            w_state_nxt = ST_IDLE;
            w_run_nxt   = 3'd0;
            w_bits_nxt  = 4'd0;
            w_count_nxt = 3'd0;
            w_bad_nxt   = 1'b0;
          end else begin
            w_run_nxt = r_run + 3'd1;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_run_nxt   = 3'd0;
          w_bits_nxt  = 4'd0;
          w_count_nxt = 3'd0;
          w_bad_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= ST_IDLE;
      r_run    <= 3'd0;
      r_bits   <= 4'd0;
      r_count  <= 3'd0;
      r_bad    <= 1'b0;
      r_letter <= 3'd0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_bits   <= w_bits_nxt;
      r_count  <= w_count_nxt;
      r_bad    <= w_bad_nxt;
      r_letter <= w_letter_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign letter       = r_letter;
  assign letter_valid = r_valid;
  assign letter_err   = r_err;
  assign busy         = (r_state != ST_IDLE);

`ifdef MORSE_DECODER_ERRCNT_EN
  // Counts on the same edge that raises letter_err, so both are visible together.
  logic [7:0] r_err_count;

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_err_count <= 8'd0;
    end else if (w_err_nxt && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_morse_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_decoder
//
// Scoreboard bench for morse_decoder. The driver issues Morse units aligned to
// the decoder's unit timer and pushes the expected letter result into a queue;
// a monitor pops and compares whenever letter_valid or letter_err pulses.
// -----------------------------------------------------------------------------
module tb_morse_decoder;

  localparam int R = 3;

  logic        clock;
  logic        aresetn;
  logic        morse_in;
  logic [31:0] rate;
  logic [2:0]  letter;
  logic        letter_valid;
  logic        letter_err;
  logic        busy;
  logic [7:0]  err_count;

  morse_decoder dut (
    .clock        (clock),
    .aresetn      (aresetn),
    .morse_in     (morse_in),
    .rate         (rate),
    .letter       (letter),
    .letter_valid (letter_valid),
    .letter_err   (letter_err),
    .busy         (busy),
    .err_count    (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       err;
    logic [2:0] letter;
    logic [7:0] ecnt;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] exp_last = 3'd0;
  int         exp_errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] model_ecnt();
`ifdef MORSE_DECODER_ERRCNT_EN
    if (exp_errs > 255) return 8'hFF;
    return exp_errs[7:0];
`else
    return 8'd0;
`endif
  endfunction

  // Monitor: one scoreboard entry per result pulse.
  always @(negedge clock) begin
    if (aresetn === 1'b1 && (letter_valid === 1'b1 || letter_err === 1'b1)) begin
      check("valid_err_exclusive", {31'd0, letter_valid & letter_err}, 32'd0);
      check("busy_after_end", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_is_err", {31'd0, letter_err}, {31'd0, mon_e.err});
        check("letter", {29'd0, letter}, {29'd0, mon_e.letter});
        check("err_count", {24'd0, err_count}, {24'd0, mon_e.ecnt});
      end
    end
  end

  // One Morse unit is held for R+1 clocks, in step with the decoder timer.
  task automatic unit(input logic b);
    morse_in = b;
    repeat (R + 1) @(negedge clock);
  endtask

  task automatic units(input logic b, input int n);
    repeat (n) unit(b);
  endtask

  task automatic expect_letter(input bit err, input logic [2:0] l);
    exp_t e;
    if (err) exp_errs++;
    else     exp_last = l;
    e.err    = err;
    e.letter = exp_last;
    e.ecnt   = model_ecnt();
    sb.push_back(e);
  endtask

  task automatic send(input string code, input bit err, input logic [2:0] l);
    expect_letter(err, l);
    for (int i = 0; i < code.len(); i++) begin
      if (i > 0) unit(1'b0);
      if (code[i] == "-") units(1'b1, 3);
      else                unit(1'b1);
      if (i == 0) check("busy_mid_letter", {31'd0, busy}, 32'd1);
    end
    units(1'b0, 3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_letter"},       {29'd0, letter},       32'd0);
    check({tag, "_letter_valid"}, {31'd0, letter_valid}, 32'd0);
    check({tag, "_letter_err"},   {31'd0, letter_err},   32'd0);
    check({tag, "_busy"},         {31'd0, busy},         32'd0);
    check({tag, "_err_count"},    {24'd0, err_count},    32'd0);
  endtask

  initial begin
    rate     = R;
    morse_in = 1'b0;
    aresetn  = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clock);
    aresetn = 1'b1;

    send("..",    1'b0, 3'b000);   // I
    send(".---",  1'b0, 3'b001);   // J
    send(".--.",  1'b0, 3'b111);   // P

    // Mark of 2 units is neither dot nor dash.
    expect_letter(1'b1, 3'b000);
    units(1'b1, 2);
    units(1'b0, 3);

    send(".....", 1'b1, 3'b000);   // five elements: overflow
    send("-.-",   1'b0, 3'b010);   // K
    send(".-..",  1'b0, 3'b011);   // L
    send("--",    1'b0, 3'b100);   // M
    send("-.",    1'b0, 3'b101);   // N
    send("---",   1'b0, 3'b110);   // O
    send(".",     1'b1, 3'b000);   // E: not in the alphabet
    send(".-",    1'b1, 3'b000);   // A: not in the alphabet

    // 2-unit gap inside a letter.
    expect_letter(1'b1, 3'b000);
    unit(1'b1);
    units(1'b0, 2);
    unit(1'b1);
    units(1'b0, 3);

    // Mark of 4 units.
    expect_letter(1'b1, 3'b000);
    units(1'b1, 4);
    units(1'b0, 3);

    // Reset after two elements of K: partial letter must vanish silently.
    units(1'b1, 3);
    unit(1'b0);
    unit(1'b1);
    unit(1'b0);
    aresetn  = 1'b0;
    morse_in = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_last = 3'd0;
    exp_errs = 0;
    repeat (3) @(negedge clock);
    aresetn = 1'b1;

    send("--", 1'b0, 3'b100);      // M after reset

    // 260 malformed letters: err_count saturates when enabled.
    for (int k = 0; k < 260; k++) begin
      expect_letter(1'b1, 3'b000);
      units(1'b1, 2);
      units(1'b0, 3);
    end

    units(1'b0, 4);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("final_err_count", {24'd0, err_count}, {24'd0, model_ecnt()});
    check("final_letter", {29'd0, letter}, 32'd4);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
